// File: rtl/seg_edit_counter.sv
// Seconds edit counter: button rises step a 0..MAX_VAL value that feeds the BCD decoder.
// Define SEG_EDIT_AUTOREPEAT_EN to build hold-to-repeat (HOLD/REPEAT states plus hold counter).
module seg_edit_counter #(
  parameter int MAX_VAL  = 59,
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edit,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [5:0] binary_out,
  output logic       EN,
  output logic       wrap
);

  localparam logic [5:0] MAX_V = 6'(MAX_VAL);

  logic       btn_up_q, btn_down_q;
  logic [5:0] count_q, count_d;
  logic       wrap_q, wrap_d;
  logic       en_q;
  logic       step_up, step_down;
  logic       up_rise, down_rise, both_btn;

  assign up_rise   = btn_up & ~btn_up_q;
  assign down_rise = btn_down & ~btn_down_q;
  assign both_btn  = btn_up & btn_down;

  // Wrap at either end so the value never leaves 0..MAX_VAL.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (step_up) begin
      if (count_q >= MAX_V) begin
        count_d = 6'd0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 6'd1;
      end
    end else if (step_down) begin
      if (count_q == 6'd0) begin
        count_d = MAX_V;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q - 6'd1;
      end
    end
  end

`ifdef SEG_EDIT_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_HOLD, S_REPEAT} state_t;

  localparam int CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d, hold_cnt_inc;
  logic          dir_up_q, dir_up_d;
  logic          held;

  assign hold_cnt_inc = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CW'(1);
  // Same button still pressed alone; anything else ends the hold.
  assign held = dir_up_q ? (btn_up & ~btn_down) : (btn_down & ~btn_up);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    dir_up_d   = dir_up_q;
    step_up    = 1'b0;
    step_down  = 1'b0;
    if (!edit) begin
      state_d    = S_IDLE;
      hold_cnt_d = '0;
    end else if (both_btn) begin
      state_d    = S_EDIT;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_EDIT;
          hold_cnt_d = '0;
        end
        S_EDIT: begin
          hold_cnt_d = '0;
          if (up_rise) begin
            step_up  = 1'b1;
            dir_up_d = 1'b1;
            state_d  = S_HOLD;
          end else if (down_rise) begin
            step_down = 1'b1;
            dir_up_d  = 1'b0;
            state_d   = S_HOLD;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (!held) begin
            state_d    = S_EDIT;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == ((state_q == S_HOLD) ? HOLD_LAST : REP_LAST)) begin
            step_up    = dir_up_q;
            step_down  = ~dir_up_q;
            state_d    = S_REPEAT;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      dir_up_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      dir_up_q   <= dir_up_d;
    end
  end
`else
  typedef enum logic {S_IDLE, S_EDIT} state_t;

  state_t state_q, state_d;
  logic   unused_params;

  assign unused_params = ^{32'(HOLD_CYC), 32'(REP_CYC)};

  always_comb begin
    state_d   = state_q;
    step_up   = 1'b0;
    step_down = 1'b0;
    if (!edit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_EDIT;
        S_EDIT: begin
          if (!both_btn) begin
            step_up   = up_rise;
            step_down = down_rise;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
      count_q    <= 6'd0;
      wrap_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      en_q       <= edit;
    end
  end

  assign binary_out = count_q;
  assign EN         = en_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_seg_edit_counter.sv
// Scoreboard bench for seg_edit_counter; expectations follow the auto-repeat macro if defined.
module tb_seg_edit_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       edit = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [5:0] binary_out;
  logic       EN;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] val;
    logic       wrap;
    logic       en;
  } exp_t;

  exp_t sb_q[$];

  seg_edit_counter #(.MAX_VAL(59), .HOLD_CYC(8), .REP_CYC(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .edit       (edit),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .binary_out (binary_out),
    .EN         (EN),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, queue the expected outputs, compare after the edge.
  task automatic drive(input string tag, input logic r, input logic e, input logic u,
                       input logic d, input logic [5:0] v, input logic w);
    exp_t x;
    reset = r; edit = e; btn_up = u; btn_down = d;
    x.val = v; x.wrap = w; x.en = r ? 1'b0 : e;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    checks++;
    if (binary_out !== x.val) begin
      errors++;
      $display("FAIL %s value: got %0d expected %0d", tag, binary_out, x.val);
    end
    checks++;
    if (wrap !== x.wrap) begin
      errors++;
      $display("FAIL %s wrap: got %b expected %b", tag, wrap, x.wrap);
    end
    checks++;
    if (EN !== x.en) begin
      errors++;
      $display("FAIL %s EN: got %b expected %b", tag, EN, x.en);
    end
    $display("txn %-10s rst=%b edit=%b up=%b dn=%b -> val=%0d wrap=%b EN=%b", tag, r, e, u, d,
             binary_out, wrap, EN);
  endtask

  task automatic pulse(input string tag, input logic up, input logic [5:0] v, input logic w);
    drive(tag, 1'b0, 1'b1, up, ~up, v, w);
    drive(tag, 1'b0, 1'b1, 1'b0, 1'b0, v, 1'b0);
  endtask

  // Reset, enter edit, then single up pulses to reach n.
  task automatic goto_val(input int n);
    drive("goto_rst", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    drive("goto_edit", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    for (int i = 1; i <= n; i++) pulse("goto", 1'b1, 6'(i), 1'b0);
  endtask

  task automatic test_reset();
    drive("reset", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    drive("reset", 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic test_wrap_up();
    drive("w_rst", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    drive("w_edit", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    pulse("dn_wrap", 1'b0, 6'd59, 1'b1);
    pulse("dn", 1'b0, 6'd58, 1'b0);
    pulse("dn", 1'b0, 6'd57, 1'b0);
    pulse("up", 1'b1, 6'd58, 1'b0);
    pulse("up", 1'b1, 6'd59, 1'b0);
    pulse("up_wrap", 1'b1, 6'd0, 1'b1);
  endtask

  task automatic test_down_wrap_and_noedit();
    pulse("dn_wrap", 1'b0, 6'd59, 1'b1);
    drive("edit_off", 1'b0, 1'b0, 1'b0, 1'b0, 6'd59, 1'b0);
    drive("noedit_up", 1'b0, 1'b0, 1'b1, 1'b0, 6'd59, 1'b0);
    drive("noedit_up", 1'b0, 1'b0, 1'b0, 1'b0, 6'd59, 1'b0);
    drive("reenter", 1'b0, 1'b1, 1'b0, 1'b0, 6'd59, 1'b0);
    pulse("resume", 1'b1, 6'd0, 1'b1);
  endtask

  task automatic test_both();
    goto_val(20);
    drive("both", 1'b0, 1'b1, 1'b1, 1'b1, 6'd20, 1'b0);
    drive("both", 1'b0, 1'b1, 1'b1, 1'b1, 6'd20, 1'b0);
    drive("both_rel", 1'b0, 1'b1, 1'b0, 1'b0, 6'd20, 1'b0);
    pulse("after_both", 1'b1, 6'd21, 1'b0);
  endtask

  task automatic test_held_at_edit();
    drive("pre_hold", 1'b0, 1'b0, 1'b1, 1'b0, 6'd21, 1'b0);
    for (int i = 0; i < 3; i++) drive("held_rise", 1'b0, 1'b1, 1'b1, 1'b0, 6'd21, 1'b0);
    drive("held_rel", 1'b0, 1'b1, 1'b0, 1'b0, 6'd21, 1'b0);
  endtask

  task automatic test_hold_repeat();
    int n;
    goto_val(10);
    for (int i = 0; i < 20; i++) begin
`ifdef SEG_EDIT_AUTOREPEAT_EN
      n = 1 + int'(i >= 8) + int'(i >= 12) + int'(i >= 16);
`else
      n = 1;
`endif
      drive("hold", 1'b0, 1'b1, 1'b1, 1'b0, 6'(10 + n), 1'b0);
    end
    for (int i = 0; i < 3; i++) drive("hold_rel", 1'b0, 1'b1, 1'b0, 1'b0, 6'(10 + n), 1'b0);
  endtask

  task automatic test_reset_mid_hold();
    int n;
    goto_val(35);
    for (int i = 0; i < 10; i++) begin
`ifdef SEG_EDIT_AUTOREPEAT_EN
      n = 1 + int'(i >= 8);
`else
      n = 1;
`endif
      drive("mid_hold", 1'b0, 1'b1, 1'b1, 1'b0, 6'(35 + n), 1'b0);
    end
    drive("mid_rst", 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 3; i++) drive("post_rst", 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    drive("post_rel", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    pulse("post_up", 1'b1, 6'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_down_wrap_and_noedit();
    test_both();
    test_held_at_edit();
    test_hold_repeat();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
